axis_addr_split: RTL and testbench

Parametrised AXI address-channel generator serving both the AXI read and write address paths of the stream engines. Accepts (address, beat-count) commands into a small queue and issues AXI bursts that never exceed a configurable maximum length and never cross a 4 KB boundary. Reports per-command completion after the last burst's address handshake. Generalises the fixed 256-beat address sequencer.

---
 rtl/axis_addr_split.sv | 146 ++++++++++++++
 tb/tb_axis_addr_split.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_addr_split.sv
// AXI address-channel burst generator: queues (address, beat-count) commands and
// splits each into bursts capped at BURST_MAX beats that never cross a 4 KB page.
module axis_addr_split #(
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int BURST_MAX      = 256,
  parameter int CMD_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      axi_aready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_alen,
  output logic                      axi_avalid,
  output logic                      done_valid,
  output logic                      busy
);

  localparam int BYTES   = AXI_DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int BEATS_W = $clog2(BURST_MAX) + 1;
  localparam int PTR_W   = $clog2(CMD_DEPTH);
  localparam int MIN_W0  = (CFG_DWIDTH > 13) ? CFG_DWIDTH : 13;
  localparam int MIN_W   = (MIN_W0 > BEATS_W) ? MIN_W0 : BEATS_W;
  localparam logic [AXI_ADDR_WIDTH-1:0] OFF_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_LOAD  = 5'b00010,
    S_CALC  = 5'b00100,
    S_ISSUE = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t r_state, w_next;

  logic [CFG_DWIDTH-1:0]     r_fifo_addr [CMD_DEPTH];
  logic [CFG_DWIDTH-1:0]     r_fifo_len  [CMD_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]            r_count;
  logic                      w_full, w_empty, w_push, w_pop;
  logic [CFG_DWIDTH-1:0]     w_head_addr, w_head_len;

  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [CFG_DWIDTH-1:0]     r_rem;
  logic [BEATS_W-1:0]        r_beats;
  logic [CFG_DWIDTH-1:0]     w_rem_after;
  logic [12:0]               w_bnd_bytes;
  logic [MIN_W-1:0]          w_bnd, w_rem_x, w_max, w_min;
  logic [BEATS_W-1:0]        w_alen_full;

  assign w_full      = (r_count == (PTR_W + 1)'(CMD_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = cfg_valid & ~w_full;
  assign w_pop       = (r_state == S_LOAD);
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_len  = r_fifo_len[r_rd_ptr];

  // NOTE: command storage has no reset; validity is carried solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= cfg_address;
      r_fifo_len[r_wr_ptr]  <= cfg_length;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Beats left before the next 4 KB page boundary, in data beats.
  assign w_bnd_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
  assign w_bnd       = MIN_W'(w_bnd_bytes >> OFF_W);
  assign w_rem_x     = MIN_W'(r_rem);
  assign w_max       = MIN_W'(BURST_MAX);
  assign w_rem_after = r_rem - CFG_DWIDTH'(r_beats);

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    w_min = w_rem_x;
    if (w_max < w_min) w_min = w_max;
    if (w_bnd < w_min) w_min = w_bnd;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_LOAD;
      S_LOAD:  w_next = (w_head_len == '0) ? S_DONE : S_CALC;
      S_CALC:  w_next = S_ISSUE;
      S_ISSUE: if (axi_aready) w_next = (w_rem_after == '0) ? S_DONE : S_CALC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_rem   <= '0;
      r_beats <= '0;
    end else if (r_state == S_LOAD) begin
      r_addr <= AXI_ADDR_WIDTH'(w_head_addr) & ~OFF_MASK;
      r_rem  <= w_head_len;
    end else if (r_state == S_CALC) begin
      r_beats <= BEATS_W'(w_min);
    end else if (r_state == S_ISSUE && axi_aready) begin
      r_addr <= r_addr + (AXI_ADDR_WIDTH'(r_beats) << OFF_W);
      r_rem  <= w_rem_after;
    end
  end

  // Address outputs are driven only from registered state, so aready never reaches them combinationally.
  assign w_alen_full = r_beats - BEATS_W'(1);
  assign axi_avalid  = (r_state == S_ISSUE);
  assign axi_aaddr   = axi_avalid ? r_addr : '0;
  assign axi_alen    = axi_avalid ? AXI_LEN_WIDTH'(w_alen_full) : '0;
  assign done_valid  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE) | ~w_empty;
  assign cfg_ready   = ~w_full;

endmodule

// File: tb/tb_axis_addr_split.sv
// Directed scoreboard bench for axis_addr_split: expected bursts and completions are
// queued as commands are driven and consumed by a monitor as the DUT issues them.
module tb_axis_addr_split;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] cfg_address, cfg_length;
  logic        cfg_valid, cfg_ready, axi_aready;
  logic [31:0] axi_aaddr;
  logic [7:0]  axi_alen;
  logic        axi_avalid, done_valid, busy;

  logic [31:0] b_cfg_address, b_cfg_length;
  logic        b_cfg_valid, b_cfg_ready, b_axi_aready;
  logic [31:0] b_axi_aaddr;
  logic [7:0]  b_axi_alen;
  logic        b_axi_avalid, b_done_valid, b_busy;

  axis_addr_split u_dut (
    .clk(clk), .rst(rst),
    .cfg_address(cfg_address), .cfg_length(cfg_length),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .axi_aready(axi_aready), .axi_aaddr(axi_aaddr), .axi_alen(axi_alen),
    .axi_avalid(axi_avalid), .done_valid(done_valid), .busy(busy)
  );

  axis_addr_split #(.BURST_MAX(16)) u_b16 (
    .clk(clk), .rst(rst),
    .cfg_address(b_cfg_address), .cfg_length(b_cfg_length),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
    .axi_aready(b_axi_aready), .axi_aaddr(b_axi_aaddr), .axi_alen(b_axi_alen),
    .axi_avalid(b_axi_avalid), .done_valid(b_done_valid), .busy(b_busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          id;
  } burst_t;

  burst_t exp_bursts[$];
  int     exp_done[$];
  int     n_checks = 0;
  int     n_err = 0;
  int     hs_count = 0;
  int     done_count = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;
  burst_t      mon_e;
  int          mon_id, mon_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_avalid", 64'(axi_avalid), 64'(1));
        check("hold_aaddr", 64'(axi_aaddr), 64'(prev_addr));
        check("hold_alen", 64'(axi_alen), 64'(prev_len));
      end
      if (axi_avalid && axi_aready) begin
        hs_count++;
        check("burst_expected", 64'(exp_bursts.size() != 0), 64'(1));
        if (exp_bursts.size() != 0) begin
          mon_e = exp_bursts.pop_front();
          check("burst_addr", 64'(axi_aaddr), 64'(mon_e.addr));
          check("burst_alen", 64'(axi_alen), 64'(mon_e.len));
        end
      end
      if (done_valid) begin
        done_count++;
        check("done_expected", 64'(exp_done.size() != 0), 64'(1));
        if (exp_done.size() != 0) begin
          mon_id   = exp_done.pop_front();
          mon_pend = 0;
          for (int i = 0; i < exp_bursts.size(); i++)
            if (exp_bursts[i].id == mon_id) mon_pend++;
          check("done_after_bursts", 64'(mon_pend), 64'(0));
        end
      end
      prev_stall = axi_avalid && !axi_aready;
      prev_addr  = axi_aaddr;
      prev_len   = axi_alen;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [7:0] len, input int id);
    burst_t e;
    e.addr = addr;
    e.len  = len;
    e.id   = id;
    exp_bursts.push_back(e);
  endtask

  task automatic push_cmd(input logic [31:0] addr, input logic [31:0] len, output logic acc);
    cfg_address = addr;
    cfg_length  = len;
    cfg_valid   = 1'b1;
    acc         = cfg_ready;
    tick();
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check(tag, 64'(busy), 64'(0));
  endtask

  task automatic wait_avalid(input string tag);
    int n = 0;
    while (!axi_avalid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(axi_avalid), 64'(1));
  endtask

  logic [31:0] b_exp_addr [3];
  logic [7:0]  b_exp_len  [3];

  initial begin
    logic acc;
    int   hs0, d0, idx, n;
    logic b_done_seen;

    b_exp_addr = '{32'h0, 32'h200, 32'h400};
    b_exp_len  = '{8'd15, 8'd15, 8'd7};

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_address = '0; cfg_length = '0; axi_aready = 1'b0;
    b_cfg_valid = 1'b0; b_cfg_address = '0; b_cfg_length = '0; b_axi_aready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_avalid", 64'(axi_avalid), 64'(0));
    check("rst_done", 64'(done_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    check("rst_aaddr", 64'(axi_aaddr), 64'(0));
    check("rst_alen", 64'(axi_alen), 64'(0));

    // 4 KB page splitting with latency checks
    axi_aready = 1'b1;
    push_exp(32'h1000, 8'd127, 1);
    push_exp(32'h2000, 8'd127, 1);
    push_exp(32'h3000, 8'd43, 1);
    exp_done.push_back(1);
    push_cmd(32'h1000, 32'd300, acc);
    check("t1_accept", 64'(acc), 64'(1));
    repeat (2) tick();
    check("t1_avalid_T3", 64'(axi_avalid), 64'(0));
    tick();
    check("t1_avalid_T4", 64'(axi_avalid), 64'(1));
    tick();
    check("t1_calc_gap", 64'(axi_avalid), 64'(0));
    tick();
    check("t1_avalid_T6", 64'(axi_avalid), 64'(1));
    repeat (3) tick();
    check("t1_done_T9", 64'(done_valid), 64'(1));
    check("t1_busy_T9", 64'(busy), 64'(1));
    tick();
    check("t1_busy_T10", 64'(busy), 64'(0));
    check("t1_done_T10", 64'(done_valid), 64'(0));
    check("t1_drain", 64'(exp_bursts.size()), 64'(0));

    // Short command straddling a page boundary
    push_exp(32'h1F80, 8'd3, 2);
    push_exp(32'h2000, 8'd5, 2);
    exp_done.push_back(2);
    push_cmd(32'h1F80, 32'd10, acc);
    wait_idle("t2_idle");
    check("t2_drain", 64'(exp_bursts.size() + exp_done.size()), 64'(0));

    // Zero-length command between two 1-beat commands
    hs0 = hs_count;
    d0  = done_count;
    push_exp(32'h40, 8'd0, 3);
    push_exp(32'h100, 8'd0, 5);
    exp_done.push_back(3);
    exp_done.push_back(4);
    exp_done.push_back(5);
    push_cmd(32'h40, 32'd1, acc);
    push_cmd(32'h80, 32'd0, acc);
    push_cmd(32'h100, 32'd1, acc);
    wait_idle("t3_idle");
    check("t3_handshakes", 64'(hs_count - hs0), 64'(2));
    check("t3_dones", 64'(done_count - d0), 64'(3));

    // Zero-length latency: done at T+3
    exp_done.push_back(6);
    push_cmd(32'h0, 32'd0, acc);
    tick();
    check("t3z_done_T2", 64'(done_valid), 64'(0));
    tick();
    check("t3z_done_T3", 64'(done_valid), 64'(1));
    tick();
    check("t3z_busy", 64'(busy), 64'(0));

    // Backpressure: one command stalled in ISSUE, then fill the queue
    axi_aready = 1'b0;
    push_exp(32'h5000, 8'd0, 7);
    exp_done.push_back(7);
    push_cmd(32'h5000, 32'd1, acc);
    wait_avalid("t4_first_avalid");
    for (int k = 0; k < 5; k++) begin
      push_cmd(32'h6000 + 32'(k) * 32'h100, 32'd2, acc);
      if (k < 4) begin
        check("t4_accept", 64'(acc), 64'(1));
        push_exp(32'h6000 + 32'(k) * 32'h100, 8'd1, 8 + k);
        exp_done.push_back(8 + k);
      end else begin
        check("t4_refuse_5th", 64'(acc), 64'(0));
      end
    end
    repeat (4) tick();
    check("t4_stall_aaddr", 64'(axi_aaddr), 64'(32'h5000));
    check("t4_cfg_ready_full", 64'(cfg_ready), 64'(0));
    axi_aready = 1'b1;
    n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    check("t4_ready_return", 64'(cfg_ready), 64'(1));
    wait_idle("t4_idle");
    check("t4_drain", 64'(exp_bursts.size() + exp_done.size()), 64'(0));

    // Reset mid-burst with two commands queued
    axi_aready = 1'b0;
    push_cmd(32'h7000, 32'd1, acc);
    wait_avalid("t5_avalid");
    push_cmd(32'h7100, 32'd1, acc);
    push_cmd(32'h7200, 32'd1, acc);
    d0 = done_count;
    rst = 1'b1;
    cfg_address = 32'h7300; cfg_length = 32'd1; cfg_valid = 1'b1;
    tick();
    rst = 1'b0;
    cfg_valid = 1'b0;
    check("t5_avalid", 64'(axi_avalid), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_aaddr", 64'(axi_aaddr), 64'(0));
    check("t5_cfg_ready", 64'(cfg_ready), 64'(1));
    axi_aready = 1'b1;
    repeat (6) tick();
    check("t5_no_ghost", 64'(busy), 64'(0));
    check("t5_no_done", 64'(done_count - d0), 64'(0));
    push_exp(32'h20, 8'd0, 13);
    exp_done.push_back(13);
    push_cmd(32'h20, 32'd1, acc);
    repeat (2) tick();
    check("t5_avalid_T3", 64'(axi_avalid), 64'(0));
    tick();
    check("t5_avalid_T4", 64'(axi_avalid), 64'(1));
    wait_idle("t5_idle");
    check("t5_drain", 64'(exp_bursts.size() + exp_done.size()), 64'(0));

    // BURST_MAX=16 instance
    b_axi_aready  = 1'b1;
    b_cfg_address = 32'h0;
    b_cfg_length  = 32'd40;
    b_cfg_valid   = 1'b1;
    tick();
    b_cfg_valid = 1'b0;
    idx = 0;
    n = 0;
    b_done_seen = 1'b0;
    while ((b_busy || idx < 3) && n < 100) begin
      if (b_axi_avalid && idx < 3) begin
        check("b16_aaddr", 64'(b_axi_aaddr), 64'(b_exp_addr[idx]));
        check("b16_alen", 64'(b_axi_alen), 64'(b_exp_len[idx]));
        idx++;
      end
      if (b_done_valid) b_done_seen = 1'b1;
      tick();
      n++;
    end
    check("b16_burst_count", 64'(idx), 64'(3));
    check("b16_done", 64'(b_done_seen), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
